fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
- Parametrised, multi-cycle IEEE-754 style floating-point multiplier. It succeeds the combinational single-precision multiplier.
- Uses an iterative radix-4 Booth mantissa multiplier, then normalisation, then five-mode rounding.
- Adds valid/ready handshakes, full special-value handling (NaN/Inf/invalid) and an inexact flag.
- Sits in the FPU ALU behind the operand dispatcher and ahead of the writeback mux.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.
- W is derived: W = 1+EXP_W+MAN_W (32 by default). BIAS = 2^(EXP_W-1)-1. ITER = ceil((MAN_W+2)/2) = 13 by default.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept an operation.
- fp_x  in  W  operand X.
- fp_y  in  W  operand Y.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 are treated as RNE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- fp_z  out  W  product.
- ovrf  out  1  overflow.
- udrf  out  1  underflow (flush to zero).
- nv  out  1  invalid operation.
- nx  out  1  inexact.

Behaviour:
- States: IDLE, MUL, RND, DONE.
- Reset (rst_n=0 at a clock edge) has priority over everything and may occur in any state:
  - state goes to IDLE, in_ready=1, out_valid=0;
  - fp_z, ovrf, udrf, nv, nx go to 0;
  - any in-flight operation is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid, latch fp_x, fp_y and r_mode, and set in_ready=0.
  - Special case → DONE next cycle, so out_valid is asserted one cycle after accept.
  - Otherwise → MUL.
- Special-case priority:
  1. Any NaN → 0x7FC00000 (canonical qNaN: exp all ones, fraction MSB 1); nv=1 only if some NaN has fraction MSB=0.
  2. Inf×0 → canonical qNaN, nv=1.
  3. Inf×(finite non-zero, or Inf) → signed Inf.
  4. Zero or subnormal operand (exp==0) → {sx^sy, 0}; subnormals are flushed; no flags.
- MUL:
  - Unsigned {1,frac_x}×{1,frac_y} via radix-4 Booth, 2 multiplier bits per cycle, ITER cycles.
  - Accumulator width is 2*(MAN_W+1)+2 bits; the final product p is 2*MAN_W+2 bits wide.
  - Exponent sum e = ex+ey-BIAS, carried signed at EXP_W+2 bits.
  - Then → RND.
- RND (1 cycle):
  - If p MSB=1, shift right by 1 and increment e.
  - Form the kept fraction (MAN_W bits), guard bit G and sticky bit S (OR of the remaining bits).
  - Increment condition per mode, with s = sx^sy:
    - RNE: G&(S|lsb);
    - RTZ: never;
    - RDN: s&(G|S);
    - RUP: !s&(G|S);
    - RMM: G.
  - nx = G|S.
  - If the increment carries out of the fraction, the fraction becomes 0 and e increments.
- Overflow (e ≥ 2^EXP_W-1 after rounding):
  - ovrf=1, nx=1.
  - Result is Inf for RNE and RMM, for RDN when s=1, and for RUP when s=0.
  - Otherwise the result is max finite: exp=2^EXP_W-2, fraction all ones.
- Underflow (e ≤ 0 before rounding):
  - Result is signed zero, udrf=1, nx=1; the rounding increment is ignored.
- After the RND cycle → DONE.
- Normal latency: accept edge to out_valid = ITER+2 cycles (15 by default).
- DONE:
  - out_valid=1. fp_z and all flags are stable and held while out_ready=0.
  - The output handshake completes when out_valid and out_ready are both 1 at a clock edge; state → IDLE and out_valid=0 next cycle.
- in_ready=1 only in IDLE, so there is no overlap between operations.
- Flags are valid only while out_valid=1 and are cleared on return to IDLE.
- Sign of every non-NaN result is sx^sy.

Test Plan:
- fp_x=fp_y=0x40400000 (3.0×3.0), r_mode=001 → fp_z=0x41100000, all flags 0, out_valid exactly 15 cycles after accept.
- fp_x=fp_y=0x3FFFFFFF → RNE: 0x407FFFFE, nx=1; RUP: 0x407FFFFF, nx=1; RTZ: 0x407FFFFE.
- fp_x=0x002DF854 (subnormal), fp_y=0xC0490FDB → fp_z=0x80000000, flags 0, out_valid 1 cycle after accept.
- fp_x=0x7F000000, fp_y=0x40000000 → RNE: 0x7F800000, ovrf=1, nx=1; RTZ: 0x7F7FFFFF, ovrf=1.
- fp_x=0x7F800000, fp_y=0x00000000 → fp_z=0x7FC00000, nv=1. fp_x=0x7FA00000 (sNaN), fp_y=1.0 → 0x7FC00000, nv=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → fp_z and flags constant, in_ready=0 throughout.
  - Drive rst_n=0 mid-MUL → next cycle out_valid=0, in_ready=1; the next operation completes correctly.

Source files
------------

// File: rtl/fp_mul_seq.sv
// Multi-cycle floating-point multiplier: radix-4 Booth mantissa product, normalise, five-mode rounding.
// valid/ready: a transfer happens on any rising edge where valid and ready are both 1; nothing else moves data.
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] fp_x,
   input  logic [W-1:0] fp_y,
   input  logic [2:0]   r_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] fp_z,
   output logic         ovrf,
   output logic         udrf,
   output logic         nv,
   output logic         nx,
   output logic [1:0]   o_dbg_state
);
   localparam int BIAS  = 2**(EXP_W-1) - 1;
   localparam int ITER  = (MAN_W + 3) / 2;
   localparam int ACC_W = 2*(MAN_W+1) + 2;
   localparam int PW    = 2*MAN_W + 2;
   localparam int MPL_W = 2*ITER + 1;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam int E_W   = EXP_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_RND, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [W-1:0]        r_x, r_y, r_z;
   logic [2:0]          r_rm;
   logic [CNT_W-1:0]    r_cnt;
   logic [ACC_W-1:0]    r_acc, r_mcand, w_pp;
   logic [MPL_W-1:0]    r_mplr;
   logic signed [E_W-1:0] r_exp, w_en, w_er;
   logic                r_ovrf, r_udrf, r_nv, r_nx;

   logic                w_s;
   logic [EXP_W-1:0]    w_ex, w_ey;
   logic [MAN_W-1:0]    w_fx, w_fy;
   logic                w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
   logic                w_special, w_sp_nv;
   logic [W-1:0]        w_sp_z;

   assign w_s  = r_x[W-1] ^ r_y[W-1];
   assign w_ex = r_x[W-2:MAN_W];
   assign w_ey = r_y[W-2:MAN_W];
   assign w_fx = r_x[MAN_W-1:0];
   assign w_fy = r_y[MAN_W-1:0];

   // Special operands short-circuit the multiplier; exp==0 covers both zero and flushed subnormals.
   always_comb begin
      w_x_nan   = (&w_ex) & (|w_fx);
      w_y_nan   = (&w_ey) & (|w_fy);
      w_x_inf   = (&w_ex) & ~(|w_fx);
      w_y_inf   = (&w_ey) & ~(|w_fy);
      w_x_zero  = ~(|w_ex);
      w_y_zero  = ~(|w_ey);
      w_special = w_x_nan | w_y_nan | w_x_inf | w_y_inf | w_x_zero | w_y_zero;
      w_sp_nv   = 1'b0;
      w_sp_z    = {w_s, {(W-1){1'b0}}};
      if (w_x_nan || w_y_nan) begin
         w_sp_z  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         w_sp_nv = (w_x_nan & ~w_fx[MAN_W-1]) | (w_y_nan & ~w_fy[MAN_W-1]);
      end else if ((w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
         w_sp_z  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         w_sp_nv = 1'b1;
      end else if (w_x_inf || w_y_inf) begin
         w_sp_z  = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // Booth digit from multiplier bits {2i+1, 2i, 2i-1}; the multiplier is zero-padded so the sum stays unsigned.
   always_comb begin
      w_pp = '0;
      case (r_mplr[2:0])
         3'b001, 3'b010: w_pp = r_mcand;
         3'b011:         w_pp = r_mcand << 1;
         3'b100:         w_pp = -(r_mcand << 1);
         3'b101, 3'b110: w_pp = -r_mcand;
         default:        w_pp = '0;
      endcase
   end

   logic [PW-1:0]    w_p, w_pn;
   logic             w_shift, w_g, w_st, w_inc, w_ovf, w_udf, w_to_inf;
   logic [MAN_W-1:0] w_kept;
   logic [MAN_W:0]   w_sum;
   logic [W-1:0]     w_rz;
   logic             w_unused;

   assign w_p      = r_acc[PW-1:0];
   assign w_shift  = w_p[PW-1];
   assign w_pn     = w_shift ? (w_p >> 1) : w_p;
   assign w_kept   = w_pn[2*MAN_W-1:MAN_W];
   assign w_g      = w_pn[MAN_W-1];
   assign w_st     = (|w_pn[MAN_W-2:0]) | (w_shift & w_p[0]);
   assign w_unused = ^{r_acc[ACC_W-1:PW], w_pn[PW-1:PW-2]};

   always_comb begin
      case (r_rm)
         3'b001:  w_inc = 1'b0;
         3'b010:  w_inc = w_s & (w_g | w_st);
         3'b011:  w_inc = ~w_s & (w_g | w_st);
         3'b100:  w_inc = w_g;
         default: w_inc = w_g & (w_st | w_kept[0]);
      endcase
      w_en     = r_exp + {{(E_W-1){1'b0}}, w_shift};
      w_sum    = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_inc};
      w_er     = w_en + {{(E_W-1){1'b0}}, w_sum[MAN_W]};
      w_udf    = int'(w_en) <= 0;
      w_ovf    = int'(w_er) >= (2**EXP_W - 1);
      w_to_inf = !((r_rm == 3'b001) || (r_rm == 3'b010 && !w_s) || (r_rm == 3'b011 && w_s));
      w_rz     = {w_s, w_er[EXP_W-1:0], w_sum[MAN_W-1:0]};
      if (w_udf)
         w_rz = {w_s, {(W-1){1'b0}}};
      else if (w_ovf)
         w_rz = w_to_inf ? {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {w_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_MUL;
         end
         S_MUL: begin
            if (r_cnt == '0) begin
               if (w_special) w_next = S_DONE;
            end else if (r_cnt == CNT_W'(ITER)) begin
               w_next = S_RND;
            end
         end
         S_RND:  w_next = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // MUL count 0 is the setup/classify cycle; counts 1..ITER are Booth steps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x <= '0; r_y <= '0; r_rm <= '0; r_cnt <= '0;
         r_acc <= '0; r_mcand <= '0; r_mplr <= '0; r_exp <= '0;
         r_z <= '0; r_ovrf <= 1'b0; r_udrf <= 1'b0; r_nv <= 1'b0; r_nx <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_x   <= fp_x;
               r_y   <= fp_y;
               r_rm  <= r_mode;
               r_cnt <= '0;
            end
            S_MUL: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == '0) begin
                  if (w_special) begin
                     r_z  <= w_sp_z;
                     r_nv <= w_sp_nv;
                  end
                  r_acc   <= '0;
                  r_mcand <= ACC_W'({1'b1, w_fx});
                  r_mplr  <= MPL_W'({1'b1, w_fy, 1'b0});
                  r_exp   <= E_W'(w_ex) + E_W'(w_ey) - E_W'(BIAS);
               end else begin
                  r_acc   <= r_acc + w_pp;
                  r_mcand <= r_mcand << 2;
                  r_mplr  <= r_mplr >> 2;
               end
            end
            S_RND: begin
               r_z    <= w_rz;
               r_udrf <= w_udf;
               r_ovrf <= ~w_udf & w_ovf;
               r_nx   <= w_udf | w_ovf | w_g | w_st;
            end
            S_DONE: if (out_ready) begin
               r_z <= '0; r_ovrf <= 1'b0; r_udrf <= 1'b0; r_nv <= 1'b0; r_nx <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign fp_z        = r_z;
   assign ovrf        = r_ovrf;
   assign udrf        = r_udrf;
   assign nv          = r_nv;
   assign nx          = r_nx;
   assign o_dbg_state = r_state;
endmodule
